// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state/cause encodings and register-match helper for the hazard stall controller.
package hazard_pkg;
  typedef enum logic [1:0] {RUN, STALL, DRAIN, COMMIT} state_e;
  typedef enum logic [1:0] {NONE, LOADUSE, BRANCH} cause_e;
  localparam logic [4:0] REG_ZERO = 5'd0;
  function automatic logic match(input logic [4:0] x, input logic [4:0] r);
    return (x == r) && (r != REG_ZERO);
  endfunction
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational RAW comparison of ID sources against EXE/MEM destinations.
module hazard_detect
  import hazard_pkg::*;
(
  input  logic [4:0] rs_i,
  input  logic [4:0] rt_i,
  input  logic       uses_rt_i,
  input  logic       branch_i,
  input  logic       jr_i,
  input  logic [4:0] exe_reg_i,
  input  logic       exe_we_i,
  input  logic       exe_mr_i,
  input  logic [4:0] mem_reg_i,
  input  logic       mem_mr_i,
  output logic [1:0] n_o,
  output cause_e     cause_o
);
  logic exe_hit, mem_hit, br, lu, b2, b1;
  assign exe_hit = match(rs_i, exe_reg_i) | (uses_rt_i & match(rt_i, exe_reg_i));
  assign mem_hit = match(rs_i, mem_reg_i) | (uses_rt_i & match(rt_i, mem_reg_i));
  assign br      = branch_i | jr_i;
  assign lu      = exe_we_i & exe_mr_i & exe_hit;
  // branches resolve in ID, so a load one stage ahead needs two cycles
  assign b2      = br & lu;
  assign b1      = br & ((exe_we_i & ~exe_mr_i & exe_hit) | (mem_mr_i & mem_hit));
  assign n_o     = b2 ? 2'd2 : (lu | b1) ? 2'd1 : 2'd0;
  assign cause_o = (b2 | b1) ? BRANCH : lu ? LOADUSE : NONE;
endmodule

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: stall/bubble/syscall-drain sequencer beside ID.
// Optional HAZARD_STATS_EN adds saturating stall/drain statistics counters.
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3
`ifdef HAZARD_STATS_EN
  , parameter int STAT_W = 32
`endif
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [4:0] IDRegisterRS_IN,
  input  logic [4:0] IDRegisterRT_IN,
  input  logic       IDUsesRT_IN,
  input  logic       Branch_IN,
  input  logic       JumpRegister_IN,
  input  logic       Syscall_IN,
  input  logic       Taken_IN,
  input  logic [4:0] EXEWriteRegister_IN,
  input  logic       EXEWriteEnable_IN,
  input  logic       EXEMemRead_IN,
  input  logic [4:0] MEMWriteRegister_IN,
  input  logic       MEMMemRead_IN,
  output logic       StallIF_OUT,
  output logic       StallIFID_OUT,
  output logic       BubbleIDEXE_OUT,
  output logic       AltPCEnable_OUT,
  output logic       SyscallCommit_OUT
`ifdef HAZARD_STATS_EN
  , output logic [STAT_W-1:0] LoadUseStalls_OUT
  , output logic [STAT_W-1:0] BranchStalls_OUT
  , output logic [STAT_W-1:0] SyscallDrains_OUT
`endif
);
  localparam logic [2:0] DRAIN_M1 = 3'(DRAIN_CYCLES - 1);
  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] n;
  cause_e     cause;
  logic       stall, commit;
  hazard_detect u_detect (
    .rs_i      (IDRegisterRS_IN),
    .rt_i      (IDRegisterRT_IN),
    .uses_rt_i (IDUsesRT_IN),
    .branch_i  (Branch_IN),
    .jr_i      (JumpRegister_IN),
    .exe_reg_i (EXEWriteRegister_IN),
    .exe_we_i  (EXEWriteEnable_IN),
    .exe_mr_i  (EXEMemRead_IN),
    .mem_reg_i (MEMWriteRegister_IN),
    .mem_mr_i  (MEMMemRead_IN),
    .n_o       (n),
    .cause_o   (cause)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      RUN: begin
        if (cause != NONE) begin
          stall = 1'b1;
          if (n == 2'd2) begin
            state_d = STALL;
            cnt_d   = 3'd1;
          end
        end else if (Syscall_IN) begin
          stall   = 1'b1;
          state_d = (DRAIN_CYCLES == 1) ? COMMIT : DRAIN;
          cnt_d   = DRAIN_M1;
        end
      end
      STALL, DRAIN: begin
        stall = 1'b1;
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = (state_q == STALL) ? RUN : COMMIT;
      end
      COMMIT: begin
        commit  = 1'b1;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  assign StallIF_OUT       = stall;
  assign StallIFID_OUT     = stall;
  assign BubbleIDEXE_OUT   = stall;
  assign AltPCEnable_OUT   = Taken_IN & ~stall;
  assign SyscallCommit_OUT = commit;
`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] lu_q, br_q, sd_q;
  logic              lu_inc, br_inc;
  // STALL is only ever entered for a branch waiting on an EXE load
  assign lu_inc = stall & (state_q == RUN) & (cause == LOADUSE);
  assign br_inc = stall & (((state_q == RUN) & (cause == BRANCH)) | (state_q == STALL));
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      lu_q <= '0;
      br_q <= '0;
      sd_q <= '0;
    end else begin
      lu_q <= (lu_inc && !(&lu_q)) ? lu_q + 1'b1 : lu_q;
      br_q <= (br_inc && !(&br_q)) ? br_q + 1'b1 : br_q;
      sd_q <= (commit && !(&sd_q)) ? sd_q + 1'b1 : sd_q;
    end
  end
  assign LoadUseStalls_OUT = lu_q;
  assign BranchStalls_OUT  = br_q;
  assign SyscallDrains_OUT = sd_q;
`endif
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller: directed-vector scoreboard bench for hazard_stall_controller.
module tb_hazard_stall_controller;
  logic       CLOCK = 1'b0, RESET = 1'b1;
  logic [4:0] rs = '0, rt = '0, ew = '0, mw = '0;
  logic       ut = 0, br = 0, jr = 0, sc = 0, tk = 0, ewe = 0, emr = 0, mmr = 0;
  logic       st_if, st_ifid, bub, alt, cm;
`ifdef HAZARD_STATS_EN
  logic [1:0] lu_c, br_c, sd_c;
`endif
  always #5 CLOCK = ~CLOCK;

  hazard_stall_controller #(
    .DRAIN_CYCLES(3)
`ifdef HAZARD_STATS_EN
    , .STAT_W(2)
`endif
  ) dut (
    .CLOCK               (CLOCK),
    .RESET               (RESET),
    .IDRegisterRS_IN     (rs),
    .IDRegisterRT_IN     (rt),
    .IDUsesRT_IN         (ut),
    .Branch_IN           (br),
    .JumpRegister_IN     (jr),
    .Syscall_IN          (sc),
    .Taken_IN            (tk),
    .EXEWriteRegister_IN (ew),
    .EXEWriteEnable_IN   (ewe),
    .EXEMemRead_IN       (emr),
    .MEMWriteRegister_IN (mw),
    .MEMMemRead_IN       (mmr),
    .StallIF_OUT         (st_if),
    .StallIFID_OUT       (st_ifid),
    .BubbleIDEXE_OUT     (bub),
    .AltPCEnable_OUT     (alt),
    .SyscallCommit_OUT   (cm)
`ifdef HAZARD_STATS_EN
    , .LoadUseStalls_OUT (lu_c)
    , .BranchStalls_OUT  (br_c)
    , .SyscallDrains_OUT (sd_c)
`endif
  );

  typedef struct {
    string nm;
    logic  st, al, co;
  } exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endfunction

  task automatic cyc(input string nm, input logic r,
                     input logic [4:0] i_rs, input logic [4:0] i_rt, input logic i_ut,
                     input logic i_br, input logic i_jr, input logic i_sc, input logic i_tk,
                     input logic [4:0] i_ew, input logic i_ewe, input logic i_emr,
                     input logic [4:0] i_mw, input logic i_mmr,
                     input logic e_st, input logic e_al, input logic e_co);
    exp_t e;
    @(posedge CLOCK);
    #1;
    RESET = r; rs = i_rs; rt = i_rt; ut = i_ut; br = i_br; jr = i_jr; sc = i_sc; tk = i_tk;
    ew = i_ew; ewe = i_ewe; emr = i_emr; mw = i_mw; mmr = i_mmr;
    e.nm = nm; e.st = e_st; e.al = e_al; e.co = e_co;
    q.push_back(e);
  endtask

  always @(negedge CLOCK) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check({e.nm, ".stall_if"}, 32'(st_if), 32'(e.st));
      check({e.nm, ".stall_ifid"}, 32'(st_ifid), 32'(e.st));
      check({e.nm, ".bubble"}, 32'(bub), 32'(e.st));
      check({e.nm, ".altpc"}, 32'(alt), 32'(e.al));
      check({e.nm, ".commit"}, 32'(cm), 32'(e.co));
    end
  end

  initial begin
    //   name           rst rs rt ut br jr sc tk  ew we mr  mw mr   stall alt commit
    cyc("reset",        1,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0,   0, 0, 0);
    cyc("idle",         0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0,   0, 0, 0);
    cyc("t5_run",       0,  0, 0, 0, 0, 0, 1, 0,  0, 0, 0,  0, 0,   1, 0, 0);
    cyc("t5_drain1",    0,  0, 0, 0, 0, 0, 1, 0,  0, 0, 0,  0, 0,   1, 0, 0);
    cyc("t5_rst",       1,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0,   0, 0, 0);
    cyc("t5_release",   0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0,   0, 0, 0);
    cyc("t5_nocommit",  0,  0, 0, 0, 0, 0, 0, 1,  0, 0, 0,  0, 0,   0, 1, 0);
    cyc("t1_loaduse",   0,  8, 8, 1, 0, 0, 0, 0,  8, 1, 1,  0, 0,   1, 0, 0);
    cyc("t1_go",        0,  8, 8, 1, 0, 0, 0, 0,  0, 0, 0,  8, 1,   0, 0, 0);
    cyc("t2_stall1",    0,  8, 0, 1, 1, 0, 0, 1,  8, 1, 1,  0, 0,   1, 0, 0);
    cyc("t2_stall2",    0,  8, 0, 1, 1, 0, 0, 1,  0, 0, 0,  8, 1,   1, 0, 0);
    cyc("t2_go",        0,  8, 0, 1, 1, 0, 0, 1,  0, 0, 0,  0, 0,   0, 1, 0);
    cyc("t4_drain1",    0,  0, 0, 0, 0, 0, 1, 0,  0, 0, 0,  0, 0,   1, 0, 0);
    cyc("t4_drain2",    0,  0, 0, 0, 0, 0, 1, 0,  0, 0, 0,  0, 0,   1, 0, 0);
    cyc("t4_drain3",    0,  0, 0, 0, 0, 0, 1, 0,  0, 0, 0,  0, 0,   1, 0, 0);
    cyc("t4_commit",    0,  0, 0, 0, 0, 0, 1, 0,  0, 0, 0,  0, 0,   0, 0, 1);
    cyc("t4_after",     0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0,   0, 0, 0);
`ifdef HAZARD_STATS_EN
    @(negedge CLOCK);
    check("stat_loaduse", 32'(lu_c), 32'd1);
    check("stat_branch", 32'(br_c), 32'd2);
    check("stat_drains", 32'(sd_c), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc("sat_lu",     0,  8, 8, 1, 0, 0, 0, 0,  8, 1, 1,  0, 0,   1, 0, 0);
      cyc("sat_go",     0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0,   0, 0, 0);
    end
    @(negedge CLOCK);
    check("stat_saturate", 32'(lu_c), 32'd3);
`endif
    cyc("t3_alu_r0",    0,  0, 0, 1, 0, 0, 0, 0,  0, 1, 0,  0, 0,   0, 0, 0);
    cyc("t3_load_r0",   0,  0, 0, 1, 1, 0, 0, 1,  0, 1, 1,  0, 1,   0, 1, 0);
    cyc("rt_unused",    0,  1, 8, 0, 0, 0, 0, 0,  8, 1, 1,  0, 0,   0, 0, 0);
    cyc("load_no_we",   0,  8, 8, 1, 0, 0, 0, 0,  8, 0, 1,  0, 0,   0, 0, 0);
    cyc("br_exe_alu",   0,  8, 0, 1, 1, 0, 0, 1,  8, 1, 0,  0, 0,   1, 0, 0);
    cyc("br_alu_go",    0,  8, 0, 1, 1, 0, 0, 1,  0, 0, 0,  8, 0,   0, 1, 0);
    cyc("jr_mem_load",  0,  9, 0, 0, 0, 1, 0, 1,  0, 0, 0,  9, 1,   1, 0, 0);
    cyc("jr_go",        0,  9, 0, 0, 0, 1, 0, 1,  0, 0, 0,  0, 0,   0, 1, 0);
    cyc("bne_rt_ld1",   0,  1, 7, 1, 1, 0, 0, 1,  7, 1, 1,  0, 0,   1, 0, 0);
    cyc("bne_rt_ld2",   0,  1, 7, 1, 1, 0, 0, 1,  0, 0, 0,  7, 1,   1, 0, 0);
    cyc("bne_rt_go",    0,  1, 7, 1, 1, 0, 0, 1,  0, 0, 0,  0, 0,   0, 1, 0);
    cyc("pri_hazard",   0,  8, 8, 1, 0, 0, 1, 0,  8, 1, 1,  0, 0,   1, 0, 0);
    cyc("pri_drain0",   0,  8, 8, 1, 0, 0, 1, 0,  0, 0, 0,  8, 1,   1, 0, 0);
    cyc("pri_drain1",   0,  8, 8, 1, 0, 0, 1, 0,  0, 0, 0,  0, 0,   1, 0, 0);
    cyc("pri_drain2",   0,  8, 8, 1, 0, 0, 1, 0,  0, 0, 0,  0, 0,   1, 0, 0);
    cyc("pri_commit",   0,  8, 8, 1, 0, 0, 1, 0,  0, 0, 0,  0, 0,   0, 0, 1);
    cyc("pri_after",    0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0,   0, 0, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge CLOCK);
    #1;
    if (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
